uart_cmd_sequencer: RTL and testbench
=====================================

# uart_cmd_sequencer

Synchronous command/response controller between the UART receiver, the accelerometer SPI reader and the UART transmitter on the DE0-Nano. It decodes single-byte axis commands, steers the accelerometer axis select, waits for a fresh sample, and emits a 3-byte response frame (header, data low, data high) through the transmitter's start/busy handshake. It replaces the ad-hoc event-clocked TxD state logic in the top level. Everything is clocked by CLK_50.

## Interface
- HEADER_BYTE, 8'h00, first byte of a normal frame
- ERR_BYTE, 8'hEE, first byte of a timeout frame
- CMD_X / CMD_Y / CMD_Z, 8'h78 / 8'h79 / 8'h7A, command codes for dimension 0 / 1 / 2
- DISCARD_SAMPLES, 1, sample_valid pulses ignored after an axis change before capture (0..15)
- TIMEOUT_CYCLES, 5_000_000, max cycles in WAIT_SAMPLE (100 ms at 50 MHz); counter width 24 bits

- CLK_50  in  1  system clock, 50 MHz
- iRSTN  in  1  asynchronous active-low reset
- rx_ready  in  1  one-cycle pulse, rx_data valid
- rx_data  in  8  received byte
- sample_valid  in  1  one-cycle pulse, data_l/data_h hold a new sample
- data_l, data_h  in  8 each  accelerometer sample for current dimension
- tx_busy  in  1  transmitter busy
- tx_start  out  1  one-cycle transmit request
- tx_data  out  8  byte to transmit, stable while tx_start high and until tx_busy falls
- dimension  out  3  axis select to SPI reader (0=x, 1=y, 2=z)
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse after last byte completes
- cmd_error  out  1  one-cycle pulse, unknown command byte in IDLE
- cmd_overrun  out  1  one-cycle pulse, rx_ready while busy
- timeout  out  1  one-cycle pulse, WAIT_SAMPLE expired

## Operation
- States: IDLE, WAIT_SAMPLE, TX_REQ, TX_WAIT_HI, TX_WAIT_LO, DONE.
- IDLE: on rx_ready with rx_data in {CMD_X,CMD_Y,CMD_Z}: register dimension, clear discard and timeout counters, go WAIT_SAMPLE. Other codes: pulse cmd_error, stay IDLE, dimension unchanged.
- WAIT_SAMPLE: each sample_valid increments discard counter; the first sample_valid seen with counter == DISCARD_SAMPLES captures {data_h,data_l} into a 16-bit hold register, loads frame = {HEADER_BYTE, data_l, data_h}, byte index = 0, go TX_REQ. Timeout counter increments each cycle; at TIMEOUT_CYCLES-1 without capture: pulse timeout, frame = {ERR_BYTE, 8'h00, 8'h00}, go TX_REQ. Capture wins if both happen in the same cycle.
- TX_REQ: wait until tx_busy = 0, then assert tx_start for exactly one cycle with tx_data = frame[index]; go TX_WAIT_HI.
- TX_WAIT_HI: wait for tx_busy = 1, then TX_WAIT_LO. If tx_busy is not seen within 4 cycles, treat byte as accepted and go TX_WAIT_LO.
- TX_WAIT_LO: wait for tx_busy = 0; if index == 2 go DONE, else index+1, go TX_REQ.
- DONE: pulse frame_done, go IDLE.
- rx_ready in any state other than IDLE: byte dropped, cmd_overrun pulsed, state and dimension unaffected.
- Captured sample is frozen; later changes to data_l/data_h do not alter an in-flight frame.

## Timing
- Reset (iRSTN low, asynchronous): state IDLE, dimension 0, tx_start 0, tx_data 8'h00, busy 0, all pulse outputs 0, counters and hold register 0. Reset mid-frame aborts immediately; no partial byte retransmitted after release.
- rx_ready at cycle C (valid command) -> dimension and busy updated at C+1.
- Capturing sample_valid at cycle S -> tx_start high at S+1 if tx_busy low (tx_data = header).
- All status pulses are exactly one cycle wide, registered.
- tx_start never asserted while tx_busy is high; tx_data changes only in TX_REQ.

## Test plan
- Reset, rx 8'h79, DISCARD_SAMPLES=1, two sample_valid pulses with data 0x1234 then 0xA5C3 -> dimension=1, tx bytes 0x00, 0xC3, 0xA5, one frame_done, busy back to 0.
- Transmitter model holding busy 10 cycles per byte -> exactly 3 tx_start pulses, each ≥1 cycle after busy fell, tx_data stable during busy.
- rx 8'h41 in IDLE -> cmd_error one pulse, dimension unchanged, no tx_start.
- rx 8'h7A, then rx 8'h78 during TX_WAIT_LO -> cmd_overrun pulse, dimension stays 2, frame completes normally.
- rx 8'h78 with no sample_valid, TIMEOUT_CYCLES=100 -> timeout pulse at cycle 100 after entry, bytes 0xEE, 0x00, 0x00.
- Assert iRSTN low during second byte -> outputs at reset values asynchronously; after release, rx 8'h78 produces a complete fresh 3-byte frame.

Source files
------------

// File: rtl/uart_cmd_sequencer_if.sv
`timescale 1ns/1ps
// Handshake and status bundle between the command sequencer and the UART RX/TX
// and accelerometer SPI reader. The sequencer is the slave side.
interface uart_cmd_sequencer_if;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       sample_valid;
  logic [7:0] data_l;
  logic [7:0] data_h;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [2:0] dimension;
  logic       busy;
  logic       frame_done;
  logic       cmd_error;
  logic       cmd_overrun;
  logic       timeout;

  modport master (
    output rx_ready, rx_data, sample_valid, data_l, data_h, tx_busy,
    input  tx_start, tx_data, dimension, busy, frame_done, cmd_error,
           cmd_overrun, timeout
  );

  modport slave (
    input  rx_ready, rx_data, sample_valid, data_l, data_h, tx_busy,
    output tx_start, tx_data, dimension, busy, frame_done, cmd_error,
           cmd_overrun, timeout
  );
endinterface

// File: rtl/uart_cmd_sequencer.sv
`timescale 1ns/1ps
// Command/response sequencer: decodes single-byte axis commands, selects the
// accelerometer axis, waits for a fresh sample and sends a 3-byte frame
// (header, data low, data high) through the UART transmitter start/busy handshake.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// IDLE        | waiting for a command byte
// WAIT_SAMPLE | axis selected, skipping stale samples, timeout running
// TX_REQ      | frame byte ready, start issued once transmitter is idle
// TX_WAIT_HI  | waiting for transmitter to go busy (gives up after 4 cycles)
// TX_WAIT_LO  | waiting for transmitter to finish the byte
// DONE        | frame complete, frame_done pulse visible
module uart_cmd_sequencer #(
  parameter int unsigned DISCARD_SAMPLES = 1,
  parameter int unsigned TIMEOUT_CYCLES  = 5_000_000
) (
  input  logic                       CLK_50,
  input  logic                       iRSTN,
  uart_cmd_sequencer_if.slave        bus
);

  localparam logic [7:0]  HEADER_BYTE  = 8'h00;
  localparam logic [7:0]  ERR_BYTE     = 8'hEE;
  localparam logic [7:0]  CMD_X        = 8'h78;
  localparam logic [7:0]  CMD_Y        = 8'h79;
  localparam logic [7:0]  CMD_Z        = 8'h7A;
  localparam logic [3:0]  DISCARD_CNT  = 4'(DISCARD_SAMPLES);
  localparam logic [23:0] TIMEOUT_LAST = 24'(TIMEOUT_CYCLES - 1);
  localparam logic [23:0] HI_WAIT_LAST = 24'd3;

  typedef enum logic [2:0] {
    IDLE, WAIT_SAMPLE, TX_REQ, TX_WAIT_HI, TX_WAIT_LO, DONE
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  dim_q, dim_d;
  logic [3:0]  disc_q, disc_d;
  // Shared counter: sample timeout in WAIT_SAMPLE, busy-rise wait in TX_WAIT_HI.
  logic [23:0] cnt_q, cnt_d;
  // Frame bytes packed as {byte2, byte1, byte0}; doubles as the frozen sample hold.
  logic [23:0] frame_q, frame_d;
  logic [1:0]  idx_q, idx_d;
  logic [1:0]  idx_nxt;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        frame_done_q, frame_done_d;
  logic        cmd_error_q, cmd_error_d;
  logic        cmd_overrun_q, cmd_overrun_d;
  logic        timeout_q, timeout_d;
  logic        tx_start;
  logic        cmd_ok;

  assign idx_nxt = idx_q + 2'd1;

  // Next-state, datapath and pulse decode.
  always_comb begin
    state_d       = state_q;
    dim_d         = dim_q;
    disc_d        = disc_q;
    cnt_d         = cnt_q;
    frame_d       = frame_q;
    idx_d         = idx_q;
    tx_data_d     = tx_data_q;
    frame_done_d  = 1'b0;
    cmd_error_d   = 1'b0;
    cmd_overrun_d = 1'b0;
    timeout_d     = 1'b0;
    tx_start      = 1'b0;
    cmd_ok        = 1'b0;

    if (bus.rx_ready && (state_q != IDLE)) cmd_overrun_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (bus.rx_ready) begin
          case (bus.rx_data)
            CMD_X:   begin dim_d = 3'd0; cmd_ok = 1'b1; end
            CMD_Y:   begin dim_d = 3'd1; cmd_ok = 1'b1; end
            CMD_Z:   begin dim_d = 3'd2; cmd_ok = 1'b1; end
            default: cmd_error_d = 1'b1;
          endcase
          if (cmd_ok) begin
            disc_d  = 4'd0;
            cnt_d   = 24'd0;
            state_d = WAIT_SAMPLE;
          end
        end
      end
      WAIT_SAMPLE: begin
        // A capture in the same cycle as the timeout expiry takes priority.
        if (bus.sample_valid && (disc_q == DISCARD_CNT)) begin
          frame_d   = {bus.data_h, bus.data_l, HEADER_BYTE};
          idx_d     = 2'd0;
          tx_data_d = HEADER_BYTE;
          state_d   = TX_REQ;
        end else begin
          if (bus.sample_valid) disc_d = disc_q + 4'd1;
          if (cnt_q == TIMEOUT_LAST) begin
            timeout_d = 1'b1;
            frame_d   = {8'h00, 8'h00, ERR_BYTE};
            idx_d     = 2'd0;
            tx_data_d = ERR_BYTE;
            state_d   = TX_REQ;
          end else begin
            cnt_d = cnt_q + 24'd1;
          end
        end
      end
      TX_REQ: begin
        if (!bus.tx_busy) begin
          tx_start = 1'b1;
          cnt_d    = 24'd0;
          state_d  = TX_WAIT_HI;
        end
      end
      TX_WAIT_HI: begin
        if (bus.tx_busy || (cnt_q == HI_WAIT_LAST)) state_d = TX_WAIT_LO;
        else cnt_d = cnt_q + 24'd1;
      end
      TX_WAIT_LO: begin
        if (!bus.tx_busy) begin
          if (idx_q == 2'd2) begin
            frame_done_d = 1'b1;
            state_d      = DONE;
          end else begin
            idx_d     = idx_nxt;
            tx_data_d = frame_q[{idx_nxt, 3'b000} +: 8];
            state_d   = TX_REQ;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any frame in flight.
  always_ff @(posedge CLK_50 or negedge iRSTN) begin
    if (!iRSTN) begin
      state_q       <= IDLE;
      dim_q         <= 3'd0;
      disc_q        <= 4'd0;
      cnt_q         <= 24'd0;
      frame_q       <= 24'd0;
      idx_q         <= 2'd0;
      tx_data_q     <= 8'h00;
      frame_done_q  <= 1'b0;
      cmd_error_q   <= 1'b0;
      cmd_overrun_q <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      dim_q         <= dim_d;
      disc_q        <= disc_d;
      cnt_q         <= cnt_d;
      frame_q       <= frame_d;
      idx_q         <= idx_d;
      tx_data_q     <= tx_data_d;
      frame_done_q  <= frame_done_d;
      cmd_error_q   <= cmd_error_d;
      cmd_overrun_q <= cmd_overrun_d;
      timeout_q     <= timeout_d;
    end
  end

  assign bus.tx_start    = tx_start;
  assign bus.tx_data     = tx_data_q;
  assign bus.dimension   = dim_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.frame_done  = frame_done_q;
  assign bus.cmd_error   = cmd_error_q;
  assign bus.cmd_overrun = cmd_overrun_q;
  assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
`timescale 1ns/1ps
// Self-checking bench for uart_cmd_sequencer: transaction-level reference model,
// per-cycle compare on the falling edge, directed scenarios plus random frames.
module tb_uart_cmd_sequencer;
  localparam int DISC = 1;
  localparam int TMO  = 100;

  logic clk_50 = 1'b0;
  logic rst_n  = 1'b0;

  uart_cmd_sequencer_if bus();

  uart_cmd_sequencer #(.DISCARD_SAMPLES(DISC), .TIMEOUT_CYCLES(TMO)) dut (
    .CLK_50(clk_50),
    .iRSTN (rst_n),
    .bus   (bus)
  );

  always #10 clk_50 = ~clk_50;

  int cyc = 0;
  always @(posedge clk_50) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // ---------------- reference model (frame-level rules) ----------------
  bit         m_busy, m_wait, m_pend, m_infl, m_seen_hi, m_fin;
  int         m_wcnt, m_scnt, m_hcnt, m_sent;
  logic [2:0] m_dim;
  bit         m_err, m_ovr, m_tmo, m_done;
  logic [7:0] m_q[$];

  task automatic model_reset();
    m_busy = 0; m_wait = 0; m_pend = 0; m_infl = 0; m_seen_hi = 0; m_fin = 0;
    m_wcnt = 0; m_scnt = 0; m_hcnt = 0; m_sent = 0; m_dim = 3'd0;
    m_err = 0; m_ovr = 0; m_tmo = 0; m_done = 0;
    m_q.delete();
  endtask

  task automatic model_step();
    bit ob, op, oi, ow;
    ob = m_busy; op = m_pend; oi = m_infl; ow = m_wait;
    if (m_fin) begin m_busy = 0; m_fin = 0; end
    m_err = 0; m_ovr = 0; m_tmo = 0; m_done = 0;
    if (bus.rx_ready) begin
      if (ob) m_ovr = 1;
      else if (bus.rx_data inside {8'h78, 8'h79, 8'h7A}) begin
        m_dim = 3'(bus.rx_data - 8'h78);
        m_busy = 1; m_wait = 1; m_wcnt = 0; m_scnt = 0; m_sent = 0;
      end else m_err = 1;
    end
    if (ow) begin
      if (bus.sample_valid && m_scnt == DISC) begin
        m_q.push_back(8'h00); m_q.push_back(bus.data_l); m_q.push_back(bus.data_h);
        m_wait = 0; m_pend = 1;
      end else begin
        if (bus.sample_valid) m_scnt++;
        if (m_wcnt == TMO - 1) begin
          m_tmo = 1;
          m_q.push_back(8'hEE); m_q.push_back(8'h00); m_q.push_back(8'h00);
          m_wait = 0; m_pend = 1;
        end else m_wcnt++;
      end
    end
    if (oi) begin
      if (!m_seen_hi) begin
        if (bus.tx_busy || m_hcnt == 3) m_seen_hi = 1;
        else m_hcnt++;
      end else if (!bus.tx_busy) begin
        m_infl = 0;
        if (m_sent == 3) begin m_done = 1; m_fin = 1; end
        else m_pend = 1;
      end
    end
    if (op && !bus.tx_busy) begin
      m_pend = 0; m_infl = 1; m_seen_hi = 0; m_hcnt = 0; m_sent++;
    end
  endtask

  initial begin : model_proc
    model_reset();
    forever begin
      @(posedge clk_50);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // ---------------- transmitter model ----------------
  int busy_len = 10;
  int lat_cfg  = 1;
  bit drop_en  = 0;

  initial begin : xmtr
    int hold, lat;
    bit st;
    hold = 0; lat = 0; bus.tx_busy = 1'b0;
    forever begin
      @(negedge clk_50);
      st = bus.tx_start && rst_n;
      @(posedge clk_50);
      #1;
      if (!rst_n) begin
        bus.tx_busy = 1'b0; hold = 0; lat = 0;
      end else begin
        if (hold > 0) begin
          hold--;
          if (hold == 0) bus.tx_busy = 1'b0;
        end else if (lat > 0) begin
          lat--;
          if (lat == 0) begin bus.tx_busy = 1'b1; hold = busy_len; end
        end
        if (st && !(drop_en && $urandom_range(0, 7) == 0)) begin
          if (lat_cfg <= 1) begin bus.tx_busy = 1'b1; hold = busy_len; end
          else lat = lat_cfg - 1;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [7:0] tx_log[$];
  logic [7:0] last_tx;
  bit         have_last = 0;
  int n_start = 0, n_done = 0, n_err = 0, n_ovr = 0, t_tmo = -1;

  initial begin : compare_proc
    bit exp_start;
    forever begin
      @(negedge clk_50);
      if (!rst_n) begin
        have_last = 0;
      end else begin
        chk("dimension", bus.dimension, m_dim);
        chk("busy", bus.busy, m_busy);
        chk("cmd_error", bus.cmd_error, m_err);
        chk("cmd_overrun", bus.cmd_overrun, m_ovr);
        chk("timeout", bus.timeout, m_tmo);
        chk("frame_done", bus.frame_done, m_done);
        exp_start = m_pend && !bus.tx_busy;
        chk("tx_start", bus.tx_start, exp_start);
        if (bus.tx_start) begin
          chk("tx_byte_available", m_q.size() > 0, 1);
          if (m_q.size() > 0) chk("tx_data", bus.tx_data, m_q.pop_front());
          last_tx = bus.tx_data; have_last = 1;
          tx_log.push_back(bus.tx_data);
          n_start++;
        end
        if (bus.tx_busy && have_last) chk("tx_data_stable", bus.tx_data, last_tx);
        if (bus.frame_done)  n_done++;
        if (bus.cmd_error)   n_err++;
        if (bus.cmd_overrun) n_ovr++;
        if (bus.timeout)     t_tmo = cyc;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk_50);
    #1;
  endtask

  task automatic send_rx(input logic [7:0] b);
    bus.rx_ready = 1'b1; bus.rx_data = b;
    tick();
    bus.rx_ready = 1'b0;
  endtask

  task automatic send_sample(input logic [15:0] d);
    bus.sample_valid = 1'b1; bus.data_l = d[7:0]; bus.data_h = d[15:8];
    tick();
    bus.sample_valid = 1'b0;
    bus.data_l = 8'($urandom); bus.data_h = 8'($urandom);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while ((m_busy || bus.busy) && n < budget) begin tick(); n++; end
    chk({name, "_idle_bound"}, n < budget, 1);
  endtask

  task automatic check_frame(input string name, input logic [7:0] b0,
                             input logic [7:0] b1, input logic [7:0] b2);
    logic [7:0] exp [3];
    exp[0] = b0; exp[1] = b1; exp[2] = b2;
    chk({name, "_byte_count"}, tx_log.size(), 3);
    for (int i = 0; i < 3; i++)
      chk({name, "_byte"}, (tx_log.size() > i) ? {24'h0, tx_log[i]} : 32'h1FF, exp[i]);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main_proc
    int t_entry, n;
    logic [7:0] cmd;
    int sv_on;
    bus.rx_ready = 1'b0; bus.rx_data = 8'h00; bus.sample_valid = 1'b0;
    bus.data_l = 8'h00; bus.data_h = 8'h00;
    rst_n = 1'b0;
    repeat (3) @(posedge clk_50);
    #1;
    chk("reset_tx_data", bus.tx_data, 8'h00);
    chk("reset_dimension", bus.dimension, 3'd0);
    chk("reset_flags", {bus.tx_start, bus.busy, bus.frame_done, bus.cmd_error,
                        bus.cmd_overrun, bus.timeout}, 6'b0);
    rst_n = 1'b1;
    tick();

    // Y command, first sample discarded, second captured.
    tx_log.delete(); n_start = 0; n_done = 0;
    send_rx(8'h79);
    repeat (2) tick();
    send_sample(16'h1234);
    repeat (3) tick();
    send_sample(16'hA5C3);
    wait_idle(200, "t1");
    check_frame("t1", 8'h00, 8'hC3, 8'hA5);
    chk("t1_starts", n_start, 3);
    chk("t1_dimension", bus.dimension, 3'd1);
    chk("t1_frame_done_count", n_done, 1);
    chk("t1_busy_low", bus.busy, 1'b0);

    // Unknown command.
    n_err = 0; n_start = 0;
    send_rx(8'h41);
    repeat (3) tick();
    chk("t2_cmd_error_count", n_err, 1);
    chk("t2_dimension", bus.dimension, 3'd1);
    chk("t2_no_start", n_start, 0);

    // Command arriving while a frame is transmitting.
    tx_log.delete(); n_ovr = 0; n_done = 0;
    send_rx(8'h7A);
    tick();
    send_sample(16'h1111);
    send_sample(16'h5A3C);
    n = 0;
    while (!bus.tx_busy && n < 50) begin tick(); n++; end
    chk("t3_busy_bound", n < 50, 1);
    repeat (3) tick();
    send_rx(8'h78);
    wait_idle(200, "t3");
    chk("t3_overrun_count", n_ovr, 1);
    chk("t3_dimension", bus.dimension, 3'd2);
    chk("t3_frame_done_count", n_done, 1);
    check_frame("t3", 8'h00, 8'h3C, 8'h5A);

    // No samples: timeout frame.
    tx_log.delete(); t_tmo = -1;
    send_rx(8'h78);
    t_entry = cyc;
    wait_idle(400, "t4");
    chk("t4_timeout_cycle", t_tmo - t_entry, 100);
    check_frame("t4", 8'hEE, 8'h00, 8'h00);

    // Reset while the second byte is on the wire.
    n_start = 0;
    send_rx(8'h7A);
    send_sample(16'h0F0F);
    send_sample(16'hBEEF);
    n = 0;
    while (n_start < 2 && n < 200) begin tick(); n++; end
    chk("t5_second_byte_bound", n < 200, 1);
    repeat (2) tick();
    #4 rst_n = 1'b0;
    #1;
    chk("t5_async_tx_start", bus.tx_start, 1'b0);
    chk("t5_async_tx_data", bus.tx_data, 8'h00);
    chk("t5_async_busy", bus.busy, 1'b0);
    chk("t5_async_dimension", bus.dimension, 3'd0);
    chk("t5_async_pulses", {bus.frame_done, bus.cmd_error, bus.cmd_overrun, bus.timeout}, 4'b0);
    @(posedge clk_50);
    @(posedge clk_50);
    #1 rst_n = 1'b1;
    tick();
    tx_log.delete(); n_start = 0; n_done = 0;
    repeat (4) tick();
    chk("t5_no_restart", n_start, 0);
    send_rx(8'h78);
    send_sample(16'h2222);
    send_sample(16'h7E81);
    wait_idle(200, "t5");
    chk("t5_starts", n_start, 3);
    chk("t5_frame_done_count", n_done, 1);
    check_frame("t5", 8'h00, 8'h81, 8'h7E);

    // Random frames with varied transmitter behaviour and stray commands.
    drop_en = 1;
    for (int f = 0; f < 40; f++) begin
      busy_len = $urandom_range(1, 12);
      lat_cfg  = $urandom_range(1, 3);
      sv_on    = ($urandom_range(0, 3) != 0);
      n = $urandom_range(0, 9);
      cmd = (n < 8) ? 8'(8'h78 + n % 3) : 8'($urandom);
      send_rx(cmd);
      for (int k = 0; k < 600 && (m_busy || bus.busy); k++) begin
        bus.sample_valid = sv_on && ($urandom_range(0, 5) == 0);
        bus.data_l = 8'($urandom); bus.data_h = 8'($urandom);
        bus.rx_ready = ($urandom_range(0, 39) == 0);
        bus.rx_data = 8'($urandom);
        tick();
      end
      bus.sample_valid = 1'b0; bus.rx_ready = 1'b0;
      wait_idle(300, "rand");
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #1_000_000;
    errors++;
    $display("FAIL watchdog actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
